// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM status, plus the arbiter state enum
// so that debug probes elsewhere can decode arbiter state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signals of the RAM arbiter.
// slave: the arbiter's view. master: requesters plus the RAM model.
interface ram_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ = 4
) ();

  logic  [NREQ-1:0] req;
  logic  [NREQ-1:0] wen;
  logic  [NREQ-1:0] blk;
  word_t [NREQ-1:0] addr;
  word_t [NREQ-1:0] wdata;
  logic  [NREQ-1:0] rwait;
  word_t [NREQ-1:0] rdata;
  logic  [NREQ-1:0] err;
  logic  [NREQ-1:0] gnt;

  word_t     ramaddr;
  word_t     ramstore;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  req, wen, blk, addr, wdata, ramload, ramstate,
    output rwait, rdata, err, gnt, ramaddr, ramstore, ramREN, ramWEN
  );

  modport master (
    output req, wen, blk, addr, wdata, ramload, ramstate,
    input  rwait, rdata, err, gnt, ramaddr, ramstore, ramREN, ramWEN
  );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester with req high, searching
// ptr+1, ptr+2, ... modulo NREQ. ptr itself is considered last.
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned idx;

  // Scan in rotated order and latch the first hit.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!any && req[IW'(idx)]) begin
        any    = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NREQ requesters.
// Holds the grant for a whole one- or two-word transfer; aborts on RAM ERROR,
// on timeout, or silently when the owner drops req.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          CLK,
  input logic          nRST,
  ram_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic [IW-1:0] pick;
  logic          pick_any;

  logic  [NREQ-1:0] rwait;
  logic  [NREQ-1:0] err;
  logic  [NREQ-1:0] gnt;
  word_t [NREQ-1:0] rdata;
  word_t            ramaddr;
  word_t            ramstore;
  logic             ramREN;
  logic             ramWEN;
  logic             own_wen;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick),
    .any    (pick_any)
  );

  // Next state and all outputs; outputs are combinational so that an
  // asynchronous reset drops the RAM strobes in the same cycle.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    tcnt_d   = tcnt_q;
    rwait    = '1;
    err      = '0;
    gnt      = '0;
    rdata    = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    own_wen  = bus.wen[sel_q];

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick;
          tcnt_d  = '0;
          state_d = XFER0;
        end
      end

      XFER0, XFER1: begin
        ramaddr      = bus.addr[sel_q];
        ramstore     = own_wen ? bus.wdata[sel_q] : '0;
        ramWEN       = own_wen;
        ramREN       = !own_wen;
        gnt[sel_q]   = 1'b1;
        rdata[sel_q] = bus.ramload;

        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q;
        end else if (bus.ramstate == ERROR) begin
          err[sel_q] = 1'b1;
          state_d    = IDLE;
          ptr_d      = sel_q;
        end else if (bus.ramstate == ACCESS) begin
          rwait[sel_q] = 1'b0;
          tcnt_d       = '0;
          if (state_q == XFER0 && bus.blk[sel_q]) begin
            state_d = XFER1;
          end else begin
            state_d = IDLE;
            ptr_d   = sel_q;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err[sel_q] = 1'b1;
          state_d    = IDLE;
          ptr_d      = sel_q;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.rwait    = rwait;
  assign bus.err      = err;
  assign bus.gnt      = gnt;
  assign bus.rdata    = rdata;
  assign bus.ramaddr  = ramaddr;
  assign bus.ramstore = ramstore;
  assign bus.ramREN   = ramREN;
  assign bus.ramWEN   = ramWEN;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus pushes expected word
// completions and error pulses; a monitor pops them as the DUT presents them.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 4;

  typedef struct {
    bit    is_err;
    int    id;
    word_t data;
    word_t addr;
    word_t store;
    bit    wr;
    int    cyc;
  } exp_t;

  logic CLK;
  logic nRST;

  ram_arbiter_if #(.NREQ(NREQ)) bus ();

  ram_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int   checks = 0;
  int   fails  = 0;
  int   events_seen = 0;
  int   ncyc = 0;
  int   wen_cycles = 0;
  int   word_cyc = 0;
  exp_t exp_q[$];

  int   lat = 0;
  bit   force_busy = 0;
  bit   force_error = 0;
  int   bcnt = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: lat BUSY cycles then ACCESS, with forced BUSY/ERROR overrides.
  always_comb begin
    if (force_error)                  bus.ramstate = ERROR;
    else if (force_busy)              bus.ramstate = BUSY;
    else if (bus.ramREN || bus.ramWEN) bus.ramstate = (bcnt >= lat) ? ACCESS : BUSY;
    else                              bus.ramstate = FREE;
    bus.ramload = (bus.ramaddr == 32'h40) ? 32'hDEAD_BEEF : (bus.ramaddr ^ 32'hC0DE_0000);
  end

  always_ff @(posedge CLK) begin
    if ((bus.ramREN || bus.ramWEN) && bus.ramstate != ACCESS) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic push_word(input int id, input word_t data, input word_t a, input word_t st,
                           input bit wr, input int cyc);
    exp_t e;
    e.is_err = 0; e.id = id; e.data = data; e.addr = a; e.store = st; e.wr = wr; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int id, input int cyc);
    exp_t e;
    e.is_err = 1; e.id = id; e.data = '0; e.addr = '0; e.store = '0; e.wr = 0; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) until n more completions/errors were seen, then step #1 past the edge.
  task automatic wait_events(input int n);
    int target;
    bit done;
    target = events_seen + n;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge CLK);
      if (events_seen >= target) done = 1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL wait_events: got %0d events, expected %0d", events_seen, target);
    end
    #1;
  endtask

  // Monitor: pops an expectation for every rwait-low or err pulse.
  initial begin
    exp_t e;
    bit   ev;
    bit   ok;
    int   cur;
    forever begin
      @(negedge CLK);
      ncyc++;
      if (bus.ramWEN) wen_cycles++;
      if (nRST) begin
        cur = (bus.gnt != '0) ? word_cyc + 1 : 0;
        ev  = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
          if (!bus.rwait[i] || bus.err[i]) begin
            ev = 1;
            events_seen++;
            checks++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL unexpected: got event on requester %0d err=%b, expected none",
                       i, bus.err[i]);
            end else begin
              e = exp_q.pop_front();
              if (e.is_err)
                ok = bus.err[i] && bus.rwait[i] && i == e.id && cur == e.cyc;
              else
                ok = !bus.rwait[i] && !bus.err[i] && i == e.id && bus.rdata[i] == e.data &&
                     bus.ramaddr == e.addr && bus.ramstore == e.store &&
                     bus.ramWEN == e.wr && bus.ramREN == !e.wr && cur == e.cyc &&
                     bus.gnt == NREQ'(1 << i);
              if (!ok) begin
                fails++;
                $display("FAIL scoreboard: got id=%0d err=%b data=%h addr=%h store=%h wen=%b cyc=%0d, expected id=%0d err=%b data=%h addr=%h store=%h wen=%b cyc=%0d",
                         i, bus.err[i], bus.rdata[i], bus.ramaddr, bus.ramstore, bus.ramWEN,
                         cur, e.id, e.is_err, e.data, e.addr, e.store, e.wr, e.cyc);
              end
            end
          end
        end
        word_cyc = ev ? 0 : cur;
        if (bus.gnt != '0) begin
          ok = $onehot(bus.gnt) && ((bus.rwait | bus.gnt) == '1) && ((bus.err & ~bus.gnt) == '0);
          for (int i = 0; i < int'(NREQ); i++)
            if (!bus.gnt[i] && bus.rdata[i] != '0) ok = 0;
          checks++;
          if (!ok) begin
            fails++;
            $display("FAIL nonowner: got gnt=%b rwait=%b err=%b, expected quiet non-owners",
                     bus.gnt, bus.rwait, bus.err);
          end
        end
      end else begin
        word_cyc = 0;
      end
    end
  end

  initial begin
    int t0;
    int e0;
    bus.req = '0; bus.wen = '0; bus.blk = '0; bus.addr = '0; bus.wdata = '0;
    nRST = 1'b0;
    #2;
    check("reset_rwait", 64'(bus.rwait), 64'hF);
    check("reset_gnt_err", 64'({bus.gnt, bus.err}), 64'h0);
    check("reset_rdata", 64'(bus.rdata != '0), 64'h0);
    check("reset_ram", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr | bus.ramstore}), 64'h0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Single read, zero-wait RAM.
    @(posedge CLK); #1;
    bus.addr[2] = 32'h40; bus.req[2] = 1'b1;
    push_word(2, 32'hDEAD_BEEF, 32'h40, 32'h0, 0, 1);
    @(posedge CLK); #1;
    check("single_gnt", 64'(bus.gnt), 64'h4);
    check("single_ren", 64'(bus.ramREN), 64'h1);
    wait_events(1);
    check("single_idle", 64'(bus.gnt), 64'h0);
    bus.req[2] = 1'b0;

    // All four requesting, zero-wait: rotates from ptr=2.
    bus.addr[0] = 32'h10; bus.addr[1] = 32'h20; bus.addr[2] = 32'h30; bus.addr[3] = 32'h50;
    bus.req = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      push_word(3, 32'hC0DE_0050, 32'h50, 32'h0, 0, 1);
      push_word(0, 32'hC0DE_0010, 32'h10, 32'h0, 0, 1);
      push_word(1, 32'hC0DE_0020, 32'h20, 32'h0, 0, 1);
      push_word(2, 32'hC0DE_0030, 32'h30, 32'h0, 0, 1);
    end
    wait_events(1);
    t0 = ncyc;
    wait_events(7);
    check("rr_spacing", 64'(ncyc - t0), 64'd14);
    bus.req = '0;

    // Block write from requester 1, two BUSY cycles per word.
    lat = 2; wen_cycles = 0;
    bus.wen[1] = 1'b1; bus.blk[1] = 1'b1; bus.addr[1] = 32'h100; bus.wdata[1] = 32'h1111_1111;
    bus.req[1] = 1'b1;
    push_word(1, 32'hC0DE_0100, 32'h100, 32'h1111_1111, 1, 3);
    push_word(1, 32'hC0DE_0104, 32'h104, 32'h2222_2222, 1, 3);
    wait_events(1);
    bus.addr[1] = 32'h104; bus.wdata[1] = 32'h2222_2222;
    wait_events(1);
    bus.req[1] = 1'b0; bus.wen[1] = 1'b0; bus.blk[1] = 1'b0;
    check("blk_wen_cycles", 64'(wen_cycles), 64'd6);

    // Timeout on requester 2, then requester 3 wins.
    lat = 0; force_busy = 1;
    bus.addr[2] = 32'h60; bus.addr[3] = 32'h70; bus.req[2] = 1'b1; bus.req[3] = 1'b1;
    push_err(2, 4);
    push_word(3, 32'hC0DE_0070, 32'h70, 32'h0, 0, 1);
    wait_events(1);
    bus.req[2] = 1'b0; force_busy = 0;
    wait_events(1);
    bus.req[3] = 1'b0;

    // ERROR during the second word of a block read.
    lat = 1;
    bus.blk[0] = 1'b1; bus.addr[0] = 32'h200; bus.req[0] = 1'b1;
    push_word(0, 32'hC0DE_0200, 32'h200, 32'h0, 0, 2);
    push_err(0, 1);
    wait_events(1);
    bus.addr[0] = 32'h201; force_error = 1;
    wait_events(1);
    bus.req[0] = 1'b0; bus.blk[0] = 1'b0; force_error = 0;

    // ptr moved to 0 after the abort: requester 1 wins over 0.
    lat = 0;
    bus.addr[1] = 32'h300; bus.addr[0] = 32'h310; bus.req[0] = 1'b1; bus.req[1] = 1'b1;
    push_word(1, 32'hC0DE_0300, 32'h300, 32'h0, 0, 1);
    push_word(0, 32'hC0DE_0310, 32'h310, 32'h0, 0, 1);
    wait_events(1);
    bus.req[1] = 1'b0;
    wait_events(1);
    bus.req[0] = 1'b0;

    // Silent abort: owner drops req mid-word.
    force_busy = 1; e0 = events_seen;
    bus.addr[2] = 32'h400; bus.req[2] = 1'b1;
    @(posedge CLK); #1;
    check("abort_gnt", 64'(bus.gnt), 64'h4);
    repeat (2) @(posedge CLK);
    #1 bus.req[2] = 1'b0;
    @(posedge CLK); #1;
    check("abort_idle", 64'(bus.gnt), 64'h0);
    check("abort_no_err", 64'(events_seen - e0), 64'h0);

    // Reset during XFER0, then requester 0 wins first.
    bus.addr[1] = 32'h500; bus.req[1] = 1'b1;
    @(posedge CLK); #1;
    check("rst_pre_gnt", 64'({bus.gnt, bus.ramREN}), 64'h5);
    #2 nRST = 1'b0;
    #1;
    check("rst_drop", 64'({bus.gnt, bus.err, bus.ramREN, bus.ramWEN}), 64'h0);
    force_busy = 0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    bus.addr[0] = 32'h600; bus.addr[3] = 32'h610; bus.req[0] = 1'b1; bus.req[3] = 1'b1;
    push_word(0, 32'hC0DE_0600, 32'h600, 32'h0, 0, 1);
    push_word(1, 32'hC0DE_0500, 32'h500, 32'h0, 0, 1);
    push_word(3, 32'hC0DE_0610, 32'h610, 32'h0, 0, 1);
    wait_events(1);
    bus.req[0] = 1'b0;
    wait_events(1);
    bus.req[1] = 1'b0;
    wait_events(1);
    bus.req[3] = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
